// File: rtl/mul_ctrl_if.sv
// HI/LO operation and multiplier handshake bundle for mul_ctrl.
// slave: the controller's view. master: the pipeline/multiplier environment's view.
interface mul_ctrl_if;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
    logic        mul_en;
    logic        mul_cancel;
    logic [32:0] mul_a;
    logic [32:0] mul_b;
    logic [65:0] mul_res;
    logic        mul_finish;

    modport slave (
        input  op_valid, op_code, rs_val, rt_val, flush, mul_res, mul_finish,
        output stall, hi, lo, err, mul_en, mul_cancel, mul_a, mul_b
    );

    modport master (
        output op_valid, op_code, rs_val, rt_val, flush, mul_res, mul_finish,
        input  stall, hi, lo, err, mul_en, mul_cancel, mul_a, mul_b
    );
endinterface

// File: rtl/mul_ctrl.sv
// HI/LO controller: sequences an external multi-cycle multiplier for
// MULT/MADD/MSUB (signed and unsigned), handles MTHI/MTLO directly,
// supports pipeline flush and a WAIT timeout.
module mul_ctrl #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        resetn,
    mul_ctrl_if.slave   bus
);
    localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MADD  = 3'd2;
    localparam logic [2:0] OP_MADDU = 3'd3;
    localparam logic [2:0] OP_MSUB  = 3'd4;
    localparam logic [2:0] OP_MSUBU = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [31:0]   r_rs;
    logic [31:0]   r_rt;
    logic [2:0]    r_op;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;
    logic [CW-1:0] r_wait_cnt;

    logic          w_is_mul;
    logic          w_accept;
    logic          w_mt;
    logic          w_finish;
    logic          w_signed;
    logic          w_stall;
    logic          w_mul_en;
    logic          w_cancel;
    logic          w_err;
    logic [63:0]   w_prod;
    logic [63:0]   w_acc;
    logic [63:0]   w_new;
    logic          w_unused_res;

    assign w_is_mul = (bus.op_code < OP_MTHI);
    assign w_accept = (r_state == S_IDLE) & bus.op_valid & ~bus.flush & w_is_mul;
    assign w_mt     = (r_state == S_IDLE) & bus.op_valid & ~bus.flush & ~w_is_mul;
    // flush wins over a finish arriving in the same cycle
    assign w_finish = (r_state == S_WAIT) & bus.mul_finish & ~bus.flush;

    // even op codes among the multiply class are the signed variants
    assign w_signed = (r_op == OP_MULT) | (r_op == OP_MADD) | (r_op == OP_MSUB);

    assign w_prod       = bus.mul_res[63:0];
    assign w_acc        = {r_hi, r_lo};
    assign w_unused_res = ^bus.mul_res[65:64];

    // result selection for the finish edge; hi/lo cannot move while busy
    always_comb begin
        w_new = w_prod;
        case (r_op)
            OP_MADD, OP_MADDU: w_new = w_acc + w_prod;
            OP_MSUB, OP_MSUBU: w_new = w_acc - w_prod;
            default:           w_new = w_prod;
        endcase
    end

    // next-state and handshake outputs
    always_comb begin
        w_next   = r_state;
        w_stall  = 1'b0;
        w_mul_en = 1'b0;
        w_cancel = 1'b0;
        w_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_stall = 1'b1;
                    w_next  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_stall = 1'b1;
                if (bus.flush) begin
                    w_cancel = 1'b1;
                    w_next   = S_IDLE;
                end else begin
                    w_mul_en = 1'b1;
                    w_next   = S_WAIT;
                end
            end
            S_WAIT: begin
                w_stall = 1'b1;
                if (bus.flush) begin
                    w_cancel = 1'b1;
                    w_next   = S_IDLE;
                end else if (bus.mul_finish) begin
                    w_next   = S_IDLE;
                end else if (r_wait_cnt == CW'(MAX_WAIT)) begin
                    w_err    = 1'b1;
                    w_cancel = 1'b1;
                    w_next   = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // operand/op latch on accept
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rs <= '0;
            r_rt <= '0;
            r_op <= '0;
        end else if (w_accept) begin
            r_rs <= bus.rs_val;
            r_rt <= bus.rt_val;
            r_op <= bus.op_code;
        end
    end

    // WAIT-cycle counter, zero on every entry to WAIT
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                r_wait_cnt <= '0;
        else if (r_state != S_WAIT) r_wait_cnt <= '0;
        else                        r_wait_cnt <= r_wait_cnt + 1'b1;
    end

    // architectural HI/LO: move-to writes and multiply results
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_mt) begin
            if (bus.op_code == OP_MTHI) r_hi <= bus.rs_val;
            else                        r_lo <= bus.rs_val;
        end else if (w_finish) begin
            {r_hi, r_lo} <= w_new;
        end
    end

    // outputs are held quiet for the whole reset assertion, whatever the inputs do
    assign bus.stall      = w_stall  & resetn;
    assign bus.mul_en     = w_mul_en & resetn;
    assign bus.mul_cancel = w_cancel & resetn;
    assign bus.err        = w_err    & resetn;
    assign bus.mul_a      = w_signed ? {r_rs[31], r_rs} : {1'b0, r_rs};
    assign bus.mul_b      = w_signed ? {r_rt[31], r_rt} : {1'b0, r_rt};
    assign bus.hi         = r_hi;
    assign bus.lo         = r_lo;
endmodule

// File: tb/tb_mul_ctrl.sv
// Bench for mul_ctrl: 3-cycle multiplier model, 64-bit HI/LO reference,
// per-cycle output comparison plus literal result checks.
module tb_mul_ctrl;
    localparam int MAXW = 15;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mul_ctrl_if u_if ();

    mul_ctrl #(.MAX_WAIT(MAXW)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (u_if)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        chk_on, chk_ab;
    logic        e_stall, e_en, e_cancel, e_err;
    logic [32:0] e_a, e_b;
    logic [31:0] m_hi, m_lo;
    bit          mul_dead, spur;

    // multiplier: product of the 33-bit signed operands, finish 3 cycles after mul_en
    logic [2:0]  m_pipe;
    logic [65:0] m_prod;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_pipe <= '0;
            m_prod <= '0;
        end else begin
            if (u_if.mul_cancel) m_pipe <= '0;
            else                 m_pipe <= {m_pipe[1:0], u_if.mul_en & ~mul_dead};
            if (u_if.mul_en)
                m_prod <= $signed({{33{u_if.mul_a[32]}}, u_if.mul_a}) *
                          $signed({{33{u_if.mul_b[32]}}, u_if.mul_b});
        end
    end
    assign u_if.mul_finish = m_pipe[2] | spur;
    assign u_if.mul_res    = m_prod;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_signed_op(input logic [2:0] op);
        return (op == 3'd0) || (op == 3'd2) || (op == 3'd4);
    endfunction

    function automatic logic [32:0] ext(input logic [2:0] op, input logic [31:0] x);
        return is_signed_op(op) ? {x[31], x} : {1'b0, x};
    endfunction

    // reference HI/LO after a completed multiply-class op
    function automatic logic [63:0] model_next(input logic [2:0] op, input logic [31:0] rs,
                                               input logic [31:0] rt, input logic [63:0] acc);
        logic signed [63:0] a, b, p;
        a = is_signed_op(op) ? {{32{rs[31]}}, rs} : {32'b0, rs};
        b = is_signed_op(op) ? {{32{rt[31]}}, rt} : {32'b0, rt};
        p = a * b;
        case (op)
            3'd2, 3'd3: return acc + p;
            3'd4, 3'd5: return acc - p;
            default:    return p;
        endcase
    endfunction

    // one compare point per cycle, on the falling edge
    always @(negedge clk) begin
        if (chk_on) begin
            check("stall",      64'(u_if.stall),      64'(e_stall));
            check("mul_en",     64'(u_if.mul_en),     64'(e_en));
            check("mul_cancel", 64'(u_if.mul_cancel), 64'(e_cancel));
            check("err",        64'(u_if.err),        64'(e_err));
            check("hi",         64'(u_if.hi),         64'(m_hi));
            check("lo",         64'(u_if.lo),         64'(m_lo));
            if (chk_ab) begin
                check("mul_a", 64'(u_if.mul_a), 64'(e_a));
                check("mul_b", 64'(u_if.mul_b), 64'(e_b));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic s, input logic en, input logic c, input logic e);
        e_stall = s; e_en = en; e_cancel = c; e_err = e;
    endtask

    // one multiply-class op; fl_at = cycle of flush (-1 none), dead = multiplier never finishes
    task automatic do_mul(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input int fl_at, input bit dead);
        int  k;
        bit  done;
        bit  tmo;
        step();
        mul_dead = dead;
        u_if.op_valid = 1'b1; u_if.op_code = op; u_if.rs_val = rs; u_if.rt_val = rt;
        u_if.flush = 1'b0;
        chk_ab = 1'b0;
        e_a = ext(op, rs); e_b = ext(op, rt);
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        k = 0; done = 1'b0;
        while (!done) begin
            step();
            k++;
            u_if.flush = (k == fl_at);
            chk_ab = 1'b1;
            tmo = dead && (k == MAXW + 2) && (k != fl_at);
            if (k == 1) set_exp(1'b1, fl_at != 1, fl_at == 1, 1'b0);
            else        set_exp(1'b1, 1'b0, (k == fl_at) || tmo, tmo);
            done = (k == fl_at) || (!dead && k == 4) || (dead && k == MAXW + 2);
        end
        step();
        u_if.flush = 1'b0; u_if.op_valid = 1'b0; chk_ab = 1'b0;
        if (!dead && k != fl_at) {m_hi, m_lo} = model_next(op, rs, rt, {m_hi, m_lo});
        set_exp(1'b0, 1'b0, 1'b0, 1'b0);
        mul_dead = 1'b0;
    endtask

    // MTHI/MTLO, optionally with flush (which must suppress the write)
    task automatic do_mt(input logic [2:0] op, input logic [31:0] rs, input bit fl);
        step();
        u_if.op_valid = 1'b1; u_if.op_code = op; u_if.rs_val = rs; u_if.flush = fl;
        chk_ab = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        u_if.op_valid = 1'b0; u_if.flush = 1'b0;
        if (!fl) begin
            if (op == 3'd6) m_hi = rs;
            else            m_lo = rs;
        end
    endtask

    task automatic lit(input string nm, input logic [31:0] hi, input logic [31:0] lo);
        check({nm, "_hi"}, 64'(u_if.hi), 64'(hi));
        check({nm, "_lo"}, 64'(u_if.lo), 64'(lo));
    endtask

    initial begin
        resetn = 1'b1; chk_on = 1'b0; chk_ab = 1'b1; spur = 1'b0; mul_dead = 1'b0;
        m_hi = '0; m_lo = '0; e_a = '0; e_b = '0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0);
        u_if.op_valid = 1'b0; u_if.op_code = '0; u_if.rs_val = '0; u_if.rt_val = '0;
        u_if.flush = 1'b0;

        // reset with a valid multiply presented: outputs must stay quiet
        #2 resetn = 1'b0; chk_on = 1'b1;
        u_if.op_valid = 1'b1; u_if.op_code = 3'd0; u_if.rs_val = 32'hFFFF_FFFF; u_if.rt_val = 32'd2;
        step();
        step();
        #6 resetn = 1'b1; u_if.op_valid = 1'b0; chk_ab = 1'b0;

        // accept straight after release; signed and unsigned products
        do_mul(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, -1, 1'b0);
        lit("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        do_mul(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, -1, 1'b0);
        lit("multu", 32'h0000_0001, 32'hFFFF_FFFE);

        // move-to then accumulate / subtract
        do_mt(3'd6, 32'd0, 1'b0);
        do_mt(3'd7, 32'd5, 1'b0);
        do_mul(3'd3, 32'd3, 32'd4, -1, 1'b0);
        lit("maddu", 32'h0, 32'd17);
        do_mul(3'd4, 32'd1, 32'd20, -1, 1'b0);
        lit("msub", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_mul(3'd2, 32'h8000_0000, 32'h8000_0000, -1, 1'b0);
        do_mul(3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);

        // flush cases: WAIT, finish+flush collision, ISSUE, and flushed MTHI
        do_mt(3'd6, 32'h1234_5678, 1'b0);
        do_mt(3'd7, 32'h1234_5678, 1'b0);
        do_mul(3'd0, 32'd7, 32'd9, 2, 1'b0);
        lit("flush_wait", 32'h1234_5678, 32'h1234_5678);
        do_mul(3'd0, 32'd7, 32'd9, 4, 1'b0);
        lit("flush_fin", 32'h1234_5678, 32'h1234_5678);
        do_mul(3'd2, 32'd3, 32'd3, 1, 1'b0);
        do_mt(3'd6, 32'hDEAD_BEEF, 1'b1);
        lit("flush_mt", 32'h1234_5678, 32'h1234_5678);

        // stray finish while idle
        step();
        spur = 1'b1;
        step();
        spur = 1'b0;

        // multiplier that never answers
        do_mul(3'd1, 32'd5, 32'd6, -1, 1'b1);
        lit("timeout", 32'h1234_5678, 32'h1234_5678);

        // reset in cycle 3 of a MULT, then a fresh MULT
        step();
        u_if.op_valid = 1'b1; u_if.op_code = 3'd0; u_if.rs_val = 32'hFFFF_FFFF; u_if.rt_val = 32'd2;
        e_a = 33'h1_FFFF_FFFF; e_b = 33'h0_0000_0002;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk_ab = 1'b1;
        set_exp(1'b1, 1'b1, 1'b0, 1'b0);
        step();
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        resetn = 1'b0; m_hi = '0; m_lo = '0; e_a = '0; e_b = '0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        #6 resetn = 1'b1; u_if.op_valid = 1'b0; chk_ab = 1'b0;
        lit("in_reset", 32'h0, 32'h0);
        do_mul(3'd0, 32'h0000_0003, 32'hFFFF_FFFE, -1, 1'b0);
        lit("after_reset", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mul_ctrl.md
MUL_CTRL -- requirements
Module: mul_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15, the maximum number of WAIT cycles before the multiply is abandoned.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port op_valid, input, 1 bit: the EX-stage HI/LO operation is valid this cycle.
REQ-005 SHALL have port op_code, input, 3 bits: 0 MULT, 1 MULTU, 2 MADD, 3 MADDU, 4 MSUB, 5 MSUBU, 6 MTHI, 7 MTLO.
REQ-006 SHALL have ports rs_val and rt_val, input, 32 bits each: the source operands.
REQ-007 SHALL have port flush, input, 1 bit: the pipeline is discarding the current operation.
REQ-008 SHALL have port stall, output, 1 bit: hold the pipeline.
REQ-009 SHALL have ports hi and lo, output, 32 bits each: the architectural HI/LO registers.
REQ-010 SHALL have port err, output, 1 bit: one-cycle timeout pulse.
REQ-011 SHALL have ports mul_en and mul_cancel, output, 1 bit each: multiplier start and abort.
REQ-012 SHALL have ports mul_a and mul_b, output, 33 bits each: the extended operands.
REQ-013 SHALL have port mul_res, input, 66 bits: the multiplier product.
REQ-014 SHALL have port mul_finish, input, 1 bit: the product is valid this cycle.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE and WAIT.
REQ-016 SHALL accept a multiply-class op (op_code 0-5) in IDLE when op_valid=1 and flush=0: latch operands and op_code, then go to ISSUE.
REQ-017 SHALL sign-extend operands of signed ops as {x[31],x} and zero-extend operands of unsigned ops as {1'b0,x}; mul_a/mul_b SHALL be driven from the latched registers and held stable through WAIT.
REQ-018 SHALL assert mul_en only in ISSUE, for exactly 1 cycle, and then go to WAIT.
REQ-019 SHALL, in WAIT on mul_finish=1 with flush=0, let P=mul_res[63:0] and update {hi,lo} at that clock edge as follows: MULT/MULTU write P; MADD/MADDU write {hi,lo}+P mod 2^64; MSUB/MSUBU write {hi,lo}-P mod 2^64. The state SHALL then return to IDLE.
REQ-020 SHALL drive stall=1 combinationally in the accept cycle and in every ISSUE/WAIT cycle, and stall=0 in IDLE otherwise.
REQ-021 SHALL give a 3-cycle multiplier: accept at cycle 0, mul_en at cycle 1, finish at cycle 4, and new hi/lo visible with stall=0 at cycle 5.
REQ-022 SHALL, for MTHI/MTLO in IDLE with op_valid=1 and flush=0, write rs_val to hi/lo at that edge, with no stall and no mul_en.
REQ-023 SHALL, on flush=1 in ISSUE or WAIT, assert mul_cancel for that cycle, suppress mul_en, return to IDLE, and leave hi/lo unchanged.
REQ-024 SHALL give flush priority when flush and mul_finish occur in the same cycle: no hi/lo write.
REQ-025 SHALL ignore op_valid while in ISSUE or WAIT; upstream holds the op because stall=1.
REQ-026 SHALL ignore mul_finish outside WAIT.
REQ-027 SHALL keep a WAIT-cycle counter cleared on entry to WAIT. If the counter reaches MAX_WAIT without mul_finish, the block SHALL assert err and mul_cancel for 1 cycle, return to IDLE, and leave hi/lo unchanged.
REQ-028 SHALL perform the accumulate using the hi/lo values at the finish edge; these values cannot change while busy.

Reset
REQ-029 SHALL, while resetn=0, immediately force the state to IDLE and force hi, lo, the latched operands, the latched op_code and the wait counter to 0.
REQ-030 SHALL, while resetn=0, force stall, err, mul_en and mul_cancel to 0 and mul_a/mul_b to 0.
REQ-031 SHALL abandon an in-flight multiply on reset assertion; no write occurs after release.
REQ-032 SHALL accept an op in the first cycle after resetn rises.

Verification
REQ-033 SHALL be tested with MULT rs=0xFFFFFFFF rt=0x00000002 against a 3-cycle multiplier model: hi=0xFFFFFFFF, lo=0xFFFFFFFE at cycle 5; stall high in cycles 0-4; mul_en high only in cycle 1.
REQ-034 SHALL be tested with MULTU rs=0xFFFFFFFF rt=0x00000002: hi=0x00000001, lo=0xFFFFFFFE.
REQ-035 SHALL be tested with MTHI 0, MTLO 5, MADDU rs=3 rt=4: hi=0, lo=17. A following MSUB rs=1 rt=20 SHALL give hi=0xFFFFFFFF, lo=0xFFFFFFFD.
REQ-036 SHALL be tested with hi=lo=0x12345678 and a MULT whose flush is asserted at cycle 2: mul_cancel high in cycle 2, stall low at cycle 3, hi/lo unchanged. A second case SHALL assert flush and mul_finish together in cycle 4 and check that no write occurs.
REQ-037 SHALL be tested with resetn pulled low at cycle 3 of a MULT: hi=lo=0, stall=0 and mul_en=0 during reset, and a fresh MULT after release completes correctly.
REQ-038 SHALL be tested with a model that never asserts mul_finish: err and mul_cancel pulse exactly once after 15 WAIT cycles, stall drops the next cycle, and hi/lo are unchanged.
